// File: rtl/tone_synth.sv
// tone_synth: multi-channel phase-accumulator tone generator.
// Note requests are synchronised and arbitrated by fixed priority, with channel 0 highest.
// The winning channel's phase increment drives a shared accumulator. The top accumulator
// bits address a synchronous wavetable ROM, and the returned sample is registered onto tono.
// Optional macro TONE_SYNTH_SYNC_SWITCH_EN enables click-free mode. In that mode, channel
// changes and releases wait for the waveform wrap (accumulator carry-out).
module tone_synth #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned PHASE_W  = 24,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned SAMPLE_W = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_CH-1:0]           note_req,
  input  logic [NUM_CH*PHASE_W-1:0]   note_inc,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [SAMPLE_W-1:0]         rom_data,
  output logic [SAMPLE_W-1:0]         tono,
  output logic                        active,
  output logic [$clog2(NUM_CH)-1:0]   active_ch,
  output logic                        phase_wrap
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StPlay = 1'b1;

  // Silence level: mid-scale of the unsigned sample range.
  localparam logic [SAMPLE_W-1:0] Mid = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [NUM_CH-1:0]   r_sync1;
  logic [NUM_CH-1:0]   r_req_s;
  logic [0:0]          r_state;
  logic [PHASE_W-1:0]  r_phase;
  logic [CH_W-1:0]     r_active_ch;
  logic                r_wrap;
  logic                r_play_d1;
  logic [SAMPLE_W-1:0] r_tono;

  logic [CH_W-1:0]     w_want;
  logic                w_want_valid;
  logic [PHASE_W-1:0]  w_inc;
  logic [PHASE_W:0]    w_sum;
  logic                w_change;
  logic                w_apply;
  logic                w_apply_wrap;

  // Two-flop synchroniser on the asynchronous button requests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_req_s <= '0;
    end else begin
      r_sync1 <= note_req;
      r_req_s <= r_sync1;
    end
  end

  // Fixed-priority arbiter: lowest set index wins.
  always_comb begin
    w_want = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (r_req_s[k]) w_want = CH_W'(k);
    end
  end

  assign w_want_valid = |r_req_s;
  assign w_inc        = note_inc[r_active_ch*PHASE_W +: PHASE_W];
  assign w_sum        = {1'b0, r_phase} + {1'b0, w_inc};
  assign w_change     = !w_want_valid || (w_want != r_active_ch);

`ifdef TONE_SYNTH_SYNC_SWITCH_EN
  // Hold changes until the wrap. A zero increment would never wrap, so switch at once.
  assign w_apply      = w_change && (w_sum[PHASE_W] || (w_inc == '0));
  // The switching cycle still performed the add, so its carry is reported.
  assign w_apply_wrap = w_sum[PHASE_W];
`else
  assign w_apply      = w_change;
  // An immediate switch discards the add, so there is no carry to report.
  assign w_apply_wrap = 1'b0;
`endif

  // Play FSM and phase accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_phase     <= '0;
      r_active_ch <= '0;
      r_wrap      <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_phase <= '0;
          r_wrap  <= 1'b0;
          if (w_want_valid) begin
            r_state     <= StPlay;
            r_active_ch <= w_want;
          end
        end
        StPlay: begin
          if (w_apply) begin
            r_phase <= '0;
            r_wrap  <= w_apply_wrap;
            if (!w_want_valid) begin
              r_state <= StIdle;
            end else begin
              r_active_ch <= w_want;
            end
          end else begin
            r_phase <= w_sum[PHASE_W-1:0];
            r_wrap  <= w_sum[PHASE_W];
          end
        end
        default: begin
          r_state <= StIdle;
          r_phase <= '0;
          r_wrap  <= 1'b0;
        end
      endcase
    end
  end

  // Output pipeline: play flag tracks the ROM latency, then the sample register.
  // The registered tono is itself the second pipeline stage behind active.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_play_d1 <= 1'b0;
      r_tono    <= Mid;
    end else begin
      r_play_d1 <= (r_state == StPlay);
      r_tono    <= r_play_d1 ? rom_data : Mid;
    end
  end

  assign rom_addr   = r_phase[PHASE_W-1 -: ADDR_W];
  assign active     = (r_state == StPlay);
  assign active_ch  = r_active_ch;
  assign phase_wrap = r_wrap;
  assign tono       = r_tono;

endmodule

// File: tb/tb_tone_synth.sv
// Directed testbench for tone_synth (NUM_CH=4, PHASE_W=24, ADDR_W=5, SAMPLE_W=4).
// Contains a synchronous ROM model and a two-deep expected-output history used to check tono.
module tb_tone_synth;

  logic        clk;
  logic        reset_n;
  logic [3:0]  note_req;
  logic [95:0] note_inc;
  logic [4:0]  rom_addr;
  logic [3:0]  rom_data;
  logic [3:0]  tono;
  logic        active;
  logic [1:0]  active_ch;
  logic        phase_wrap;

  int errors = 0;
  int checks = 0;

  // Expected (active, rom_addr) one and two samples back, feeding the tono prediction.
  logic       h1_act, h2_act;
  logic [4:0] h1_addr, h2_addr;

  tone_synth #(
    .NUM_CH  (4),
    .PHASE_W (24),
    .ADDR_W  (5),
    .SAMPLE_W(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .note_req  (note_req),
    .note_inc  (note_inc),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .tono      (tono),
    .active    (active),
    .active_ch (active_ch),
    .phase_wrap(phase_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] rom_f(input logic [4:0] a);
    return 4'((int'(a) * 7 + 3) % 16);
  endfunction

  // Synchronous wavetable ROM: one cycle of read latency.
  always_ff @(posedge clk) rom_data <= rom_f(rom_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Advance one clock, then check every output against the expected values.
  task automatic step(input logic ea, input int ech, input int eaddr, input logic ew,
                      input string tag);
    logic [3:0] et;
    @(posedge clk);
    #1;
    et = h2_act ? rom_f(h2_addr) : 4'd8;
    chk({tag, ".active"}, 32'(active), 32'(ea));
    chk({tag, ".ch"},     32'(active_ch), 32'(ech));
    chk({tag, ".addr"},   32'(rom_addr), 32'(eaddr));
    chk({tag, ".wrap"},   32'(phase_wrap), 32'(ew));
    chk({tag, ".tono"},   32'(tono), 32'(et));
    h2_act  = h1_act;
    h2_addr = h1_addr;
    h1_act  = ea;
    h1_addr = 5'(eaddr);
  endtask

  // Release channel 0 when it is at rom_addr 4 with an increment of 0x200000.
  task automatic release_ch0();
    note_req = 4'b0000;
`ifdef TONE_SYNTH_SYNC_SWITCH_EN
    for (int k = 1; k <= 7; k++) step(k < 7, 0, (4 + 4 * k) % 32, k == 7, "rel");
`else
    step(1, 0, 8, 0, "rel");
    step(1, 0, 12, 0, "rel");
    step(0, 0, 0, 0, "rel");
`endif
    step(0, 0, 0, 0, "rel_idle");
  endtask

  initial begin
    h1_act = 1'b0; h2_act = 1'b0; h1_addr = '0; h2_addr = '0;
    reset_n  = 1'b0;
    note_req = 4'b0000;
    note_inc = {24'h400000, 24'h000000, 24'h100000, 24'h200000};
    #12;
    chk("rst.tono", 32'(tono), 32'd8);
    chk("rst.addr", 32'(rom_addr), 32'd0);
    chk("rst.active", 32'(active), 32'd0);
    chk("rst.wrap", 32'(phase_wrap), 32'd0);
    reset_n = 1'b1;
    step(0, 0, 0, 0, "idle");
    step(0, 0, 0, 0, "idle");

    // Channel 0: active after 3 cycles, address steps of 4, wrap every 8 adds.
    note_req = 4'b0001;
    step(0, 0, 0, 0, "ch0_sync");
    step(0, 0, 0, 0, "ch0_sync");
    step(1, 0, 0, 0, "ch0_go");
    for (int i = 1; i <= 8; i++) step(1, 0, (4 * i) % 32, i == 8, "ch0_run");

    // Release from address 0, then keep stepping until the FSM is idle.
    note_req = 4'b0000;
`ifdef TONE_SYNTH_SYNC_SWITCH_EN
    for (int i = 1; i <= 8; i++) step(i < 8, 0, (4 * i) % 32, i == 8, "rel0");
`else
    step(1, 0, 4, 0, "rel0");
    step(1, 0, 8, 0, "rel0");
    step(0, 0, 0, 0, "rel0");
`endif
    step(0, 0, 0, 0, "rel0_idle");

    // 1010: channel 1 wins. 1011: switch to channel 0, restarting at address 0.
    note_req = 4'b1010;
    step(0, 0, 0, 0, "ch1_sync");
    step(0, 0, 0, 0, "ch1_sync");
    step(1, 1, 0, 0, "ch1_go");
    step(1, 1, 2, 0, "ch1_run");
    step(1, 1, 4, 0, "ch1_run");
    note_req = 4'b1011;
`ifdef TONE_SYNTH_SYNC_SWITCH_EN
    for (int k = 3; k <= 16; k++) step(1, k < 16 ? 1 : 0, (2 * k) % 32, k == 16, "sw10");
`else
    step(1, 1, 6, 0, "sw10");
    step(1, 1, 8, 0, "sw10");
    step(1, 0, 0, 0, "sw10");
`endif
    step(1, 0, 4, 0, "sw10_ch0");
    release_ch0();

    // Channel 2 has a zero increment: the address stays frozen, and channel 0 takes over at once.
    note_req = 4'b0100;
    step(0, 0, 0, 0, "ch2_sync");
    step(0, 0, 0, 0, "ch2_sync");
    step(1, 2, 0, 0, "ch2_go");
    step(1, 2, 0, 0, "ch2_frozen");
    note_req = 4'b0101;
    step(1, 2, 0, 0, "ch2_frozen");
    step(1, 2, 0, 0, "ch2_frozen");
    step(1, 0, 0, 0, "sw20");
    step(1, 0, 4, 0, "sw20_ch0");
    release_ch0();

    // A single-cycle pulse on channel 3 still passes the synchroniser as one cycle of request.
    note_req = 4'b1000;
    step(0, 0, 0, 0, "p3");
    note_req = 4'b0000;
    step(0, 0, 0, 0, "p3");
    step(1, 3, 0, 0, "p3_go");
`ifdef TONE_SYNTH_SYNC_SWITCH_EN
    for (int k = 1; k <= 4; k++) step(k < 4, 3, (8 * k) % 32, k == 4, "p3_run");
`else
    step(0, 3, 0, 0, "p3_drop");
`endif
    step(0, 3, 0, 0, "p3_idle");

    // Asynchronous reset in the middle of a note, followed by release with no requests.
    note_req = 4'b0001;
    step(0, 3, 0, 0, "pre_rst");
    step(0, 3, 0, 0, "pre_rst");
    step(1, 0, 0, 0, "pre_rst");
    step(1, 0, 4, 0, "pre_rst");
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst.tono", 32'(tono), 32'd8);
    chk("mid_rst.addr", 32'(rom_addr), 32'd0);
    chk("mid_rst.active", 32'(active), 32'd0);
    chk("mid_rst.wrap", 32'(phase_wrap), 32'd0);
    chk("mid_rst.ch", 32'(active_ch), 32'd0);
    note_req = 4'b0000;
    h1_act = 1'b0; h2_act = 1'b0;
    #3;
    reset_n = 1'b1;
    step(0, 0, 0, 0, "post_rst");
    step(0, 0, 0, 0, "post_rst");
    step(0, 0, 0, 0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
